// File: rtl/fifo_arb_ctrl.sv
// Round-robin write arbiter and pointer/count controller for a shared
// circular buffer with external storage and a single registered consumer.
module fifo_arb_ctrl #(
    parameter int NUM_REQ = 3,
    parameter int DATA_W  = 4,
    parameter int DEPTH   = 10,
    parameter int AW      = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        grant,
    input  logic                      cons_req,
    output logic                      cons_valid,
    output logic [DATA_W-1:0]         cons_data,
    output logic                      mem_we,
    output logic [AW-1:0]             mem_waddr,
    output logic [DATA_W-1:0]         mem_wdata,
    output logic [AW-1:0]             mem_raddr,
    input  logic [DATA_W-1:0]         mem_rdata,
    output logic                      full,
    output logic                      empty,
    output logic [AW-1:0]             count
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [IW-1:0] last_gnt;
    logic [IW-1:0] winner;
    logic [IW-1:0] cand;
    logic          any_gnt;
    logic          pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == AW'(DEPTH));
    assign empty = (count == '0);
    assign pop   = cons_req && !empty;

    // Search starts one past the last winner so every requester is reached.
    always_comb begin
        grant   = '0;
        winner  = last_gnt;
        cand    = last_gnt;
        any_gnt = 1'b0;
        if (!reset && !full) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                cand = IW'((int'(last_gnt) + k) % NUM_REQ);
                if (!any_gnt && req[cand]) begin
                    any_gnt = 1'b1;
                    winner  = cand;
                end
            end
        end
        if (any_gnt) begin
            grant[winner] = 1'b1;
        end
    end

    assign mem_we    = any_gnt;
    assign mem_waddr = wptr;
    assign mem_wdata = req_data[int'(winner)*DATA_W +: DATA_W];
    assign mem_raddr = rptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            last_gnt   <= IW'(NUM_REQ - 1);
            cons_valid <= 1'b0;
            cons_data  <= '0;
        end else begin
            if (any_gnt) begin
                wptr     <= wrap_inc(wptr);
                last_gnt <= winner;
            end
            if (pop) begin
                rptr <= wrap_inc(rptr);
            end
            case ({any_gnt, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // Underflow clears the data word; an idle cycle keeps it.
            if (cons_req) begin
                cons_valid <= !empty;
                cons_data  <= empty ? '0 : mem_rdata;
            end else begin
                cons_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (count <= AW'(DEPTH));
            assert ($onehot0(grant));
            assert (!(full && (|grant)));
        end
    end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Bench for fifo_arb_ctrl: directed plan steps plus random traffic,
// checked against a queue-based model of the shared buffer.
module tb_fifo_arb_ctrl;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 4;
    localparam int DEPTH   = 10;
    localparam int AW      = 4;

    logic                      clk = 1'b0;
    logic                      reset = 1'b1;
    logic [NUM_REQ-1:0]        req = '0;
    logic [NUM_REQ*DATA_W-1:0] req_data = '0;
    logic [NUM_REQ-1:0]        grant;
    logic                      cons_req = 1'b0;
    logic                      cons_valid;
    logic [DATA_W-1:0]         cons_data;
    logic                      mem_we;
    logic [AW-1:0]             mem_waddr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [AW-1:0]             mem_raddr;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      full;
    logic                      empty;
    logic [AW-1:0]             count;

    fifo_arb_ctrl #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data),
        .grant(grant), .cons_req(cons_req), .cons_valid(cons_valid),
        .cons_data(cons_data), .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata), .full(full), .empty(empty),
        .count(count)
    );

    always #5 clk = ~clk;

    // External storage the controller addresses.
    logic [DATA_W-1:0] store [2**AW];
    always @(posedge clk) if (mem_we) store[mem_waddr] <= mem_wdata;
    assign mem_rdata = store[mem_raddr];

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q[$];
    int last = NUM_REQ - 1;
    int wp = 0;
    int rp = 0;
    logic ev = 1'b0;
    logic [DATA_W-1:0] ed = '0;
    logic [NUM_REQ-1:0] egnt;
    int gcnt [NUM_REQ];

    logic [NUM_REQ-1:0]        pend = '0;
    logic [NUM_REQ*DATA_W-1:0] pdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic [NUM_REQ-1:0] rq,
                        input logic [NUM_REQ*DATA_W-1:0] rd,
                        input logic cr);
        int win;
        logic [DATA_W-1:0] wd;
        @(negedge clk);
        reset = r; req = rq; req_data = rd; cons_req = cr;
        #1;
        egnt = '0;
        win = -1;
        wd = '0;
        if (!r && q.size() < DEPTH) begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                if (win < 0 && rq[(last + k) % NUM_REQ]) win = (last + k) % NUM_REQ;
            end
        end
        if (win >= 0) begin
            egnt[win] = 1'b1;
            wd = rd[win*DATA_W +: DATA_W];
        end
        chk("grant", 32'(grant), 32'(egnt));
        chk("mem_we", 32'(mem_we), 32'(win >= 0));
        if (win >= 0) begin
            chk("mem_waddr", 32'(mem_waddr), 32'(wp));
            chk("mem_wdata", 32'(mem_wdata), 32'(wd));
        end
        if (!r) begin
            chk("mem_raddr", 32'(mem_raddr), 32'(rp));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("empty", 32'(empty), 32'(q.size() == 0));
        end
        @(posedge clk);
        if (r) begin
            q.delete();
            last = NUM_REQ - 1; wp = 0; rp = 0; ev = 1'b0; ed = '0;
        end else begin
            if (cr) begin
                if (q.size() > 0) begin
                    ed = q.pop_front(); ev = 1'b1; rp = (rp + 1) % DEPTH;
                end else begin
                    ed = '0; ev = 1'b0;
                end
            end else begin
                ev = 1'b0;
            end
            if (win >= 0) begin
                q.push_back(wd); wp = (wp + 1) % DEPTH; last = win;
                gcnt[win]++;
            end
        end
        #1;
        chk("cons_valid", 32'(cons_valid), 32'(ev));
        chk("cons_data", 32'(cons_data), 32'(ed));
        chk("count", 32'(count), 32'(q.size()));
    endtask

    // Producers hold a word until granted; consumer pops with pct chance.
    task automatic rand_ops(input int n, input int pct);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!pend[j] && $urandom_range(0, 2) == 0) begin
                    pend[j] = 1'b1;
                    pdata[j*DATA_W +: DATA_W] = DATA_W'($urandom);
                end
            end
            step(1'b0, pend, pdata, $urandom_range(0, 99) < pct);
            pend = pend & ~egnt;
        end
    endtask

    initial begin
        for (int j = 0; j < NUM_REQ; j++) gcnt[j] = 0;

        step(1'b1, '0, '0, 1'b0);
        step(1'b1, '0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0);
        chk("idle_empty", 32'(empty), 32'd1);

        for (int i = 1; i <= 5; i++) step(1'b0, 3'b001, 12'(i), 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, '0, '0, 1'b1);
            chk("in_order", 32'(cons_data), 32'(i));
        end
        chk("drained", 32'(count), 32'd0);

        for (int j = 0; j < NUM_REQ; j++) gcnt[j] = 0;
        for (int i = 0; i < 9; i++) step(1'b0, 3'b111, 12'hCBA, 1'b0);
        chk("rr_count", 32'(count), 32'd9);
        for (int j = 0; j < NUM_REQ; j++) chk("rr_share", 32'(gcnt[j]), 32'd3);

        step(1'b0, 3'b001, 12'h005, 1'b0);
        chk("filled", 32'(full), 32'd1);
        step(1'b0, 3'b111, 12'hCBA, 1'b0);
        chk("full_block", 32'(grant), 32'd0);
        step(1'b0, 3'b001, 12'h006, 1'b1);
        step(1'b0, 3'b001, 12'h006, 1'b0);
        chk("late_grant", 32'(count), 32'(DEPTH));
        rand_ops(25, 50);

        while (q.size() > 0) step(1'b0, '0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk("underflow", 32'(cons_valid), 32'd0);
        step(1'b0, 3'b001, 12'h007, 1'b1);
        step(1'b0, '0, '0, 1'b1);
        chk("no_bypass", 32'(cons_data), 32'h7);

        for (int i = 0; i < 6; i++) step(1'b0, 3'b010, 12'(i << 4), 1'b0);
        chk("pre_reset", 32'(count), 32'd6);
        step(1'b1, 3'b111, 12'h321, 1'b1);
        chk("mid_reset", 32'(count), 32'd0);
        step(1'b0, 3'b111, 12'h321, 1'b0);
        chk("first_after_rst", 32'(dut.last_gnt), 32'd0);

        rand_ops(150, 25);
        rand_ops(150, 75);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
